// File: rtl/step_button_ctrl.sv
// Two-button front end: sync, debounce, step pulse with optional auto-repeat, dir toggle.
// Optional feature: define AUTO_REPEAT_EN to enable auto-repeat while step is held.
module step_button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 64,
  parameter int REPEAT_CYCLES   = 32,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_step,
  input  logic btn_dir,
  output logic nxt,
  output logic dir,
  output logic busy
);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2 || HOLD_CYCLES < 1 ||
      (2 ** CNT_W) <= DEBOUNCE_CYCLES ||
      (2 ** CNT_W) <= HOLD_CYCLES ||
      (2 ** CNT_W) <= REPEAT_CYCLES) begin : g_bad_cfg
    $error("step_button_ctrl: invalid parameter set");
  end

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  // bit 0 = step, bit 1 = dir
  logic [1:0] raw;
  logic [1:0] s1, s2, s3;
  logic [1:0] stab, stab_n;
  logic [1:0] armed, armed_n;
  logic [1:0] rise, rise_n;
  logic [CNT_W-1:0] db_cnt [2];
  logic [CNT_W-1:0] db_n   [2];

  assign raw = {btn_dir, btn_step};

  // armed stays low after reset until a genuine low level has been seen,
  // so a button held through reset never counts as a press.
  always_comb begin
    stab_n  = stab;
    armed_n = armed;
    rise_n  = '0;
    db_n    = '{default: '0};
    for (int i = 0; i < 2; i++) begin
      if (s2[i] != s3[i]) begin
        db_n[i] = (s2[i] != stab[i]) ? CNT_W'(1) : '0;
      end else if (s2[i] != stab[i]) begin
        if (db_cnt[i] == DB_LAST) begin
          stab_n[i] = s2[i];
          rise_n[i] = s2[i] & armed[i];
          if (!s2[i]) armed_n[i] = 1'b1;
        end else begin
          db_n[i] = db_cnt[i] + CNT_W'(1);
        end
      end else if (!armed[i] && !stab[i]) begin
        if (db_cnt[i] == DB_LAST) armed_n[i] = 1'b1;
        else db_n[i] = db_cnt[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= '0;
      s2     <= '0;
      s3     <= '0;
      stab   <= '0;
      armed  <= '0;
      rise   <= '0;
      db_cnt <= '{default: '0};
    end else begin
      s1     <= raw;
      s2     <= s1;
      s3     <= s2;
      stab   <= stab_n;
      armed  <= armed_n;
      rise   <= rise_n;
      db_cnt <= db_n;
    end
  end

  typedef enum logic [1:0] {
    IDLE,
    PRESSED
`ifdef AUTO_REPEAT_EN
    , REPEAT
`endif
  } state_t;

  state_t state_q, state_n;
  logic [CNT_W-1:0] hold_q, hold_n;
`ifdef AUTO_REPEAT_EN
  logic [CNT_W-1:0] rep_q, rep_n;
`endif
  logic req;
  logic pend;
  logic emit;

  always_comb begin
    state_n = state_q;
    hold_n  = hold_q;
    req     = 1'b0;
`ifdef AUTO_REPEAT_EN
    rep_n   = rep_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (rise[0]) begin
          req     = 1'b1;
          hold_n  = '0;
          state_n = PRESSED;
        end
      end
      PRESSED: begin
        if (!stab[0]) begin
          state_n = IDLE;
        end else if (hold_q == HOLD_LAST) begin
`ifdef AUTO_REPEAT_EN
          req     = 1'b1;
          rep_n   = '0;
          state_n = REPEAT;
`endif
        end else begin
          hold_n = hold_q + CNT_W'(1);
        end
      end
`ifdef AUTO_REPEAT_EN
      REPEAT: begin
        if (!stab[0]) begin
          state_n = IDLE;
        end else if (rep_q == REP_LAST) begin
          req   = 1'b1;
          rep_n = '0;
        end else begin
          rep_n = rep_q + CNT_W'(1);
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // a pulse colliding with a dir toggle waits one cycle so dir settles first
  assign emit = ~nxt & ~rise[1] & (pend | req);
  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
`ifdef AUTO_REPEAT_EN
      rep_q   <= '0;
`endif
      pend    <= 1'b0;
      nxt     <= 1'b0;
      dir     <= 1'b0;
    end else begin
      state_q <= state_n;
      hold_q  <= hold_n;
`ifdef AUTO_REPEAT_EN
      rep_q   <= rep_n;
`endif
      pend    <= (pend | req) & ~emit;
      nxt     <= emit;
      dir     <= dir ^ rise[1];
    end
  end

endmodule
